// File: rtl/sprite_rom_arbiter.sv
// Three-requester round-robin arbiter in front of a shared 1-cycle synchronous sprite ROM.
// Latency: 3 cycles from accept to o_Rsp_Valid, one request per cycle sustained.
// Backpressure: o_Req_Ready grants one requester per cycle; responses are never stalled.
// Optional feature: SPRITE_ARB_BG_PRIORITY_EN gives the background requester (0) strict priority.
module sprite_rom_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 9
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [2:0]              i_Req_Valid,
    input  logic [3*ADDR_WIDTH-1:0] i_Req_Addr,
    output logic [2:0]              o_Req_Ready,
    output logic [ADDR_WIDTH-1:0]   o_Mem_Addr,
    output logic                    o_Mem_En,
    input  logic [DATA_WIDTH-1:0]   i_Mem_Data,
    output logic [2:0]              o_Rsp_Valid,
    output logic [DATA_WIDTH-1:0]   o_Rsp_Data
);

    logic [1:0]            r_ptr;
    logic [1:0]            ptr_nxt;
    logic [2:0]            grant;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // One-hot owner tags riding alongside the ROM access: tag1 = address cycle, tag2 = data cycle.
    logic [2:0]            tag1;
    logic [2:0]            tag2;

    always_comb begin
        grant = 3'b000;
        if (!i_Reset) begin
`ifdef SPRITE_ARB_BG_PRIORITY_EN
            if (i_Req_Valid[0]) begin
                grant = 3'b001;
            end else if (r_ptr == 2'd2) begin
                if (i_Req_Valid[2])      grant = 3'b100;
                else if (i_Req_Valid[1]) grant = 3'b010;
            end else begin
                if (i_Req_Valid[1])      grant = 3'b010;
                else if (i_Req_Valid[2]) grant = 3'b100;
            end
`else
            case (r_ptr)
                2'd1: begin
                    if (i_Req_Valid[1])      grant = 3'b010;
                    else if (i_Req_Valid[2]) grant = 3'b100;
                    else if (i_Req_Valid[0]) grant = 3'b001;
                end
                2'd2: begin
                    if (i_Req_Valid[2])      grant = 3'b100;
                    else if (i_Req_Valid[0]) grant = 3'b001;
                    else if (i_Req_Valid[1]) grant = 3'b010;
                end
                default: begin
                    if (i_Req_Valid[0])      grant = 3'b001;
                    else if (i_Req_Valid[1]) grant = 3'b010;
                    else if (i_Req_Valid[2]) grant = 3'b100;
                end
            endcase
`endif
        end
    end

    assign o_Req_Ready = grant;

    // Pointer moves past the winner; under background priority a win by requester 0 leaves it alone.
    always_comb begin
        ptr_nxt = r_ptr;
        case (grant)
`ifndef SPRITE_ARB_BG_PRIORITY_EN
            3'b001:  ptr_nxt = 2'd1;
`endif
            3'b010:  ptr_nxt = 2'd2;
            3'b100:  ptr_nxt = 2'd0;
            default: ptr_nxt = r_ptr;
        endcase
    end

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < 3; k++) begin
            if (grant[k]) sel_addr = i_Req_Addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_ptr       <= 2'd0;
            o_Mem_En    <= 1'b0;
            o_Mem_Addr  <= '0;
            tag1        <= 3'b000;
            tag2        <= 3'b000;
            o_Rsp_Valid <= 3'b000;
            o_Rsp_Data  <= '0;
        end else begin
            r_ptr       <= ptr_nxt;
            o_Mem_En    <= |grant;
            if (|grant) o_Mem_Addr <= sel_addr;
            tag1        <= grant;
            tag2        <= tag1;
            o_Rsp_Valid <= tag2;
            if (|tag2) o_Rsp_Data <= i_Mem_Data;
        end
    end

    a_grant_onehot: assert property (@(posedge i_Clk) $onehot0(o_Req_Ready));
    a_grant_needs_valid: assert property (@(posedge i_Clk) (o_Req_Ready & ~i_Req_Valid) == 3'b000);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed vector bench for sprite_rom_arbiter with a behavioural 1-cycle ROM.
module tb_sprite_rom_arbiter;

    localparam int AW = 13;
    localparam int DW = 9;
    localparam logic [AW-1:0] A0 = 13'h0010;
    localparam logic [AW-1:0] A1 = 13'h0421;
    localparam logic [AW-1:0] A2 = 13'h0802;
    localparam logic [DW-1:0] D0 = 9'h145;
    localparam logic [DW-1:0] D1 = 9'h1A5;
    localparam logic [DW-1:0] D2 = 9'h157;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req_valid = 3'b000;
    logic [3*AW-1:0] req_addr = {A2, A1, A0};
    logic [2:0]      req_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_en;
    logic [DW-1:0]   mem_data = '0;
    logic [2:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Addr  (req_addr),
        .o_Req_Ready (req_ready),
        .o_Mem_Addr  (mem_addr),
        .o_Mem_En    (mem_en),
        .i_Mem_Data  (mem_data),
        .o_Rsp_Valid (rsp_valid),
        .o_Rsp_Data  (rsp_data)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 13'h0421) return 9'h1A5;
        return a[8:0] ^ 9'h155;
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_data <= rom_word(mem_addr);
    end

    task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %h required %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]    valid;
        logic [2:0]    ready;
        logic          en;
        logic [AW-1:0] maddr;
        logic [2:0]    rsp;
        logic [DW-1:0] data;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] r, input logic e,
                                input logic [AW-1:0] a, input logic [2:0] s, input logic [DW-1:0] d);
        vec_t t;
        t.valid = v; t.ready = r; t.en = e; t.maddr = a; t.rsp = s; t.data = d;
        return t;
    endfunction

    task automatic step(input int cyc, input logic r, input logic [2:0] v, input vec_t e, input logic full);
        @(negedge clk);
        rst = r;
        req_valid = v;
        #1;
        chk("ready", cyc, {13'd0, req_ready}, {13'd0, e.ready});
        if (full) begin
            chk("mem_en", cyc, {15'd0, mem_en}, {15'd0, e.en});
            chk("mem_addr", cyc, {3'd0, mem_addr}, {3'd0, e.maddr});
            chk("rsp_valid", cyc, {13'd0, rsp_valid}, {13'd0, e.rsp});
            chk("rsp_data", cyc, {7'd0, rsp_data}, {7'd0, e.data});
        end
    endtask

    vec_t vecs[23];

    initial begin
        // Reset with every requester asking: nothing may be granted, all state clears.
        step(100, 1'b1, 3'b111, mk(3'b111, 3'b000, 0, 13'h0, 3'b000, 9'h0), 1'b0);
        step(101, 1'b1, 3'b111, mk(3'b111, 3'b000, 0, 13'h0, 3'b000, 9'h0), 1'b1);

`ifndef SPRITE_ARB_BG_PRIORITY_EN
        // All valid: 0,1,2,0,1,2 then drain.
        vecs[0]  = mk(3'b111, 3'b001, 0, 13'h0, 3'b000, 9'h0);
        vecs[1]  = mk(3'b111, 3'b010, 1, A0, 3'b000, 9'h0);
        vecs[2]  = mk(3'b111, 3'b100, 1, A1, 3'b000, 9'h0);
        vecs[3]  = mk(3'b111, 3'b001, 1, A2, 3'b001, D0);
        vecs[4]  = mk(3'b111, 3'b010, 1, A0, 3'b010, D1);
        vecs[5]  = mk(3'b111, 3'b100, 1, A1, 3'b100, D2);
        vecs[6]  = mk(3'b000, 3'b000, 1, A2, 3'b001, D0);
        vecs[7]  = mk(3'b000, 3'b000, 0, A2, 3'b010, D1);
        vecs[8]  = mk(3'b000, 3'b000, 0, A2, 3'b100, D2);
        vecs[9]  = mk(3'b000, 3'b000, 0, A2, 3'b000, D2);
        // Grant 0 alone to move the pointer to 1, then requesters 0 and 2: 2,0,2.
        vecs[10] = mk(3'b001, 3'b001, 0, A2, 3'b000, D2);
        vecs[11] = mk(3'b101, 3'b100, 1, A0, 3'b000, D2);
        vecs[12] = mk(3'b101, 3'b001, 1, A2, 3'b000, D2);
        vecs[13] = mk(3'b101, 3'b100, 1, A0, 3'b001, D0);
        vecs[14] = mk(3'b000, 3'b000, 1, A2, 3'b100, D2);
        vecs[15] = mk(3'b000, 3'b000, 0, A2, 3'b001, D0);
        vecs[16] = mk(3'b000, 3'b000, 0, A2, 3'b100, D2);
        vecs[17] = mk(3'b000, 3'b000, 0, A2, 3'b000, D2);
        // Lone frog request at 0x0421 returning 0x1A5.
        vecs[18] = mk(3'b010, 3'b010, 0, A2, 3'b000, D2);
        vecs[19] = mk(3'b000, 3'b000, 1, A1, 3'b000, D2);
        vecs[20] = mk(3'b000, 3'b000, 0, A1, 3'b000, D2);
        vecs[21] = mk(3'b000, 3'b000, 0, A1, 3'b010, D1);
        vecs[22] = mk(3'b000, 3'b000, 0, A1, 3'b000, D1);

        for (int i = 0; i < 23; i++) begin
            step(i, 1'b0, vecs[i].valid, vecs[i], 1'b1);
        end

        // Two accepts (pointer is 2 here), then reset before either response.
        step(200, 1'b0, 3'b111, mk(3'b111, 3'b100, 0, A1, 3'b000, D1), 1'b1);
        step(201, 1'b0, 3'b111, mk(3'b111, 3'b001, 1, A2, 3'b000, D1), 1'b1);
        step(202, 1'b1, 3'b111, mk(3'b111, 3'b000, 1, A0, 3'b000, D1), 1'b1);
        step(203, 1'b0, 3'b000, mk(3'b000, 3'b000, 0, 13'h0, 3'b000, 9'h0), 1'b1);
        step(204, 1'b0, 3'b000, mk(3'b000, 3'b000, 0, 13'h0, 3'b000, 9'h0), 1'b1);
        step(205, 1'b0, 3'b000, mk(3'b000, 3'b000, 0, 13'h0, 3'b000, 9'h0), 1'b1);
        step(206, 1'b0, 3'b111, mk(3'b111, 3'b001, 0, 13'h0, 3'b000, 9'h0), 1'b1);
        step(207, 1'b0, 3'b000, mk(3'b000, 3'b000, 1, A0, 3'b000, 9'h0), 1'b1);
`else
        // Background priority: 0 wins four times, then 1 and 2 alternate.
        step(300, 1'b0, 3'b111, mk(3'b111, 3'b001, 0, 13'h0, 3'b000, 9'h0), 1'b1);
        step(301, 1'b0, 3'b111, mk(3'b111, 3'b001, 1, A0, 3'b000, 9'h0), 1'b1);
        step(302, 1'b0, 3'b111, mk(3'b111, 3'b001, 1, A0, 3'b000, 9'h0), 1'b1);
        step(303, 1'b0, 3'b111, mk(3'b111, 3'b001, 1, A0, 3'b001, D0), 1'b1);
        step(304, 1'b0, 3'b110, mk(3'b110, 3'b010, 1, A0, 3'b001, D0), 1'b1);
        step(305, 1'b0, 3'b110, mk(3'b110, 3'b100, 1, A1, 3'b001, D0), 1'b1);
        step(306, 1'b0, 3'b110, mk(3'b110, 3'b010, 1, A2, 3'b001, D0), 1'b1);
        step(307, 1'b0, 3'b000, mk(3'b000, 3'b000, 1, A1, 3'b010, D1), 1'b1);
        step(308, 1'b0, 3'b000, mk(3'b000, 3'b000, 0, A1, 3'b100, D2), 1'b1);
        step(309, 1'b0, 3'b000, mk(3'b000, 3'b000, 0, A1, 3'b010, D1), 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 13, shared sprite ROM address width: 3-bit sprite select plus 10-bit pixel offset within a 32x32 tile.
REQ-002 Parameter DATA_WIDTH, 9, pixel width in RGB 3:3:3.
REQ-003 i_Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_Reset  input  1  synchronous, active-high reset.
REQ-005 i_Req_Valid  input  3  per-requester read request; bit 0 background, bit 1 frog, bit 2 obstacles.
REQ-006 i_Req_Addr  input  3*ADDR_WIDTH  packed request addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 o_Req_Ready  output  3  one-hot grant, combinational from i_Req_Valid and the priority pointer.
REQ-008 o_Mem_Addr  output  ADDR_WIDTH  registered address to the shared 1-cycle synchronous ROM.
REQ-009 o_Mem_En  output  1  registered ROM read enable.
REQ-010 i_Mem_Data  input  DATA_WIDTH  ROM read data, valid one cycle after o_Mem_En.
REQ-011 o_Rsp_Valid  output  3  registered one-hot response strobe identifying the owner of o_Rsp_Data.
REQ-012 o_Rsp_Data  output  DATA_WIDTH  registered pixel returned to the requester.

Function
REQ-013 A request from requester k SHALL transfer in any cycle where i_Req_Valid[k] and o_Req_Ready[k] are both 1.
REQ-014 A requester SHALL hold valid high with a stable address until transfer; the arbiter SHALL NOT latch requests that are not granted.
REQ-015 At most one o_Req_Ready bit SHALL be set per cycle, and o_Req_Ready SHALL be 0 whenever i_Req_Valid is 0.
REQ-016 Grant order SHALL be round-robin: search from pointer r_Ptr (0..2) upward with wrap 2->0, granting the first valid requester.
REQ-017 After a grant to k, r_Ptr SHALL become (k+1) mod 3; with no grant, r_Ptr SHALL hold.
REQ-018 Pipeline: accept in cycle N -> o_Mem_En=1 with o_Mem_Addr equal to the accepted address in cycle N+1 -> ROM data in N+2 -> o_Rsp_Valid[k]=1 with o_Rsp_Data=i_Mem_Data in N+3; fixed latency 3.
REQ-019 Throughput SHALL be one request per cycle sustained with no bubbles; the 2-stage one-hot tag pipeline SHALL track the owner.
REQ-020 o_Mem_En SHALL be 0 and o_Mem_Addr SHALL hold its last value in cycles following no transfer.
REQ-021 o_Rsp_Valid SHALL be 0 in cycles with no response; o_Rsp_Data SHALL hold its last value.
REQ-022 Responses SHALL NOT be back-pressured; requesters consume them in the strobe cycle.
REQ-023 Addresses SHALL pass unmodified; no arithmetic on them.

Reset
REQ-024 While i_Reset=1, these values SHALL apply at the next edge: r_Ptr=0, o_Mem_En=0, o_Mem_Addr=0, tag pipeline=0, o_Rsp_Valid=0, o_Rsp_Data=0.
REQ-025 While i_Reset=1, o_Req_Ready SHALL be 0 and no transfer SHALL occur.
REQ-026 Reset mid-operation SHALL discard in-flight reads; no o_Rsp_Valid SHALL follow for requests accepted before reset.

Configuration
REQ-027 Macro SPRITE_ARB_BG_PRIORITY_EN defined: requester 0 SHALL win whenever i_Req_Valid[0]=1; requesters 1 and 2 SHALL round-robin between themselves only in cycles where requester 0 is idle; r_Ptr SHALL update only on grants to 1 or 2.
REQ-028 Macro SPRITE_ARB_BG_PRIORITY_EN undefined: pure 3-way round-robin per REQ-016 and REQ-017.
REQ-029 The macro SHALL NOT change latency, ports or reset values.

Verification
REQ-030 Reset, then all valid held high for 6 cycles (macro undefined) -> grants 0,1,2,0,1,2; o_Rsp_Valid sequence 001,010,100,... starting 3 cycles after the first grant.
REQ-031 Single request from requester 1 with address 0x0421 and ROM word 0x1A5 -> o_Mem_Addr=0x0421 with o_Mem_En=1 one cycle later; o_Rsp_Valid=010 and o_Rsp_Data=0x1A5 three cycles after the grant.
REQ-032 Valid on requesters 0 and 2 only, r_Ptr=1 -> requester 2 is granted first, then 0, then 2.
REQ-033 Accept 2 back-to-back requests, assert i_Reset for 1 cycle before their responses -> o_Rsp_Valid stays 000 and r_Ptr=0 after reset.
REQ-034 With SPRITE_ARB_BG_PRIORITY_EN defined, all valid for 4 cycles, then requester 0 drops -> 0,0,0,0,1,2,1 grant sequence.
